// File: rtl/fpaddsub_pkg.sv
// Shared FP add/sub constants, stage record types and result packing helper.
// Used by the alignment, adder and normalize/pack blocks.
package fpaddsub_pkg;

    localparam int SUM_W   = 33;
    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    // Packed single-precision result layout
    localparam int RES_W        = 32;
    localparam int RES_SIGN_POS = 31;
    localparam int RES_EXP_LSB  = 23;
    localparam int RES_FRAC_LSB = 0;

    // Normalized mantissa: hidden + 23 fraction + guard + round + 6 sticky-source bits
    localparam int MANT_W = 32;
    localparam int LZC_W  = 6;

    // Two guard bits above EXP_W so cexp+2 and cexp-32 both fit without wrap
    localparam int SEXP_W = EXP_W + 2;
    typedef logic signed [SEXP_W-1:0] sexp_t;

    typedef struct packed {
        logic             vld;
        logic [SUM_W-1:0] sum;
        logic [EXP_W-1:0] cexp;
        logic             sign;
        logic             carry;
        logic             zero;
        logic [LZC_W-1:0] lzc;
    } s1_t;

    typedef struct packed {
        logic              vld;
        logic [MANT_W-1:0] mant;
        logic              sticky;
        sexp_t             exp;
        logic              sign;
        logic              zero;
        logic              unf;
    } s2_t;

    function automatic logic [RES_W-1:0] pack_result(
        input logic              sign,
        input logic [EXP_W-1:0]  exp,
        input logic [FRAC_W-1:0] frac
    );
        logic [RES_W-1:0] r;
        r = '0;
        r[RES_SIGN_POS]              = sign;
        r[RES_EXP_LSB +: EXP_W]      = exp;
        r[RES_FRAC_LSB +: FRAC_W]    = frac;
        return r;
    endfunction

endpackage

// File: rtl/fpaddsub_lzc32.sv
// Purpose: leading-zero count of a 32-bit word (32 when the word is zero).
// Latency: combinational.
// Backpressure: none, pure function of the input.
module fpaddsub_lzc32
    import fpaddsub_pkg::*;
(
    input  logic [31:0]      din,
    output logic [LZC_W-1:0] cnt
);

    // Scanning upward lets the highest set bit win the last assignment
    always_comb begin
        cnt = LZC_W'(32);
        for (int i = 0; i < 32; i++) begin
            if (din[i]) begin
                cnt = LZC_W'(31 - i);
            end
        end
    end

endmodule

// File: rtl/fpaddsub_normalize_pack.sv
// Purpose: normalize raw mantissa sum, round to nearest-even, pack IEEE-754 single.
// Latency: 3 cycles, one beat per cycle when downstream is ready.
// Backpressure: single global enable; all stages freeze while output is held unaccepted.
module fpaddsub_normalize_pack
    import fpaddsub_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_sum,
    input  logic [EXP_W-1:0] in_cexp,
    input  logic             in_sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_result,
    output logic             out_ovf,
    output logic             out_unf,
    output logic             out_zero
);

    logic             adv;
    logic [LZC_W-1:0] lzc;
    s1_t              s1_d, s1_q;
    s2_t              s2_d, s2_q;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---------------- S1: classify ----------------
    fpaddsub_lzc32 u_lzc (
        .din (in_sum[SUM_W-2:0]),
        .cnt (lzc)
    );

    always_comb begin
        s1_d       = '0;
        s1_d.vld   = in_valid;
        s1_d.sum   = in_sum;
        s1_d.cexp  = in_cexp;
        s1_d.sign  = in_sign;
        s1_d.carry = in_sum[SUM_W-1];
        s1_d.zero  = (in_sum == '0);
        s1_d.lzc   = lzc;
    end

    // ---------------- S2: shift and exponent adjust ----------------
    always_comb begin
        s2_d      = '0;
        s2_d.vld  = s1_q.vld;
        s2_d.sign = s1_q.sign;
        s2_d.zero = s1_q.zero;
        if (s1_q.carry) begin
            s2_d.mant   = s1_q.sum[SUM_W-1:1];
            s2_d.sticky = s1_q.sum[0];
            s2_d.exp    = $signed({2'b00, s1_q.cexp}) + sexp_t'(1);
        end else begin
            s2_d.mant   = s1_q.sum[SUM_W-2:0] << s1_q.lzc;
            s2_d.sticky = 1'b0;
            s2_d.exp    = $signed({2'b00, s1_q.cexp}) - $signed({4'b0000, s1_q.lzc});
        end
        // Equivalent to the adjusted exponent landing at or below zero
        s2_d.unf = !s1_q.zero && !s1_q.carry && ({2'b00, s1_q.lzc} >= s1_q.cexp);
    end

    // ---------------- S3: round and pack ----------------
    logic [FRAC_W:0]   kept;
    logic              g_bit, r_bit, s_bit, inc, rnd_cy, ovf;
    logic [FRAC_W-1:0] frac;
    sexp_t             e_rnd;
    logic [RES_W-1:0]  res_d;
    logic              ovf_d, unf_d, zero_d;

    always_comb begin
        kept  = s2_q.mant[MANT_W-1:MANT_W-FRAC_W-1];
        g_bit = s2_q.mant[7];
        r_bit = s2_q.mant[6];
        s_bit = (|s2_q.mant[5:0]) | s2_q.sticky;
        inc   = g_bit & (r_bit | s_bit | kept[0]);

        // An all-ones significand rolls over to 1.0 of the next binade
        rnd_cy = inc & (&kept);
        frac   = kept[FRAC_W-1:0] + FRAC_W'(inc);
        e_rnd  = rnd_cy ? (s2_q.exp + sexp_t'(1)) : s2_q.exp;
        ovf    = (e_rnd >= sexp_t'(EXP_MAX));

        res_d  = '0;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        zero_d = 1'b0;
        if (s2_q.zero) begin
            zero_d = s2_q.vld;
        end else if (s2_q.unf) begin
            res_d = pack_result(s2_q.sign, '0, '0);
            unf_d = s2_q.vld;
        end else if (ovf) begin
            res_d = pack_result(s2_q.sign, EXP_W'(EXP_MAX), '0);
            ovf_d = s2_q.vld;
        end else begin
            res_d = pack_result(s2_q.sign, e_rnd[EXP_W-1:0], frac);
        end
    end

    // ---------------- register banks ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_ovf    <= 1'b0;
            out_unf    <= 1'b0;
            out_zero   <= 1'b0;
        end else if (adv) begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            out_valid  <= s2_q.vld;
            out_result <= res_d;
            out_ovf    <= ovf_d;
            out_unf    <= unf_d;
            out_zero   <= zero_d;
        end
    end

endmodule

// File: tb/tb_fpaddsub_normalize_pack.sv
// Bench for fpaddsub_normalize_pack: directed vectors, backpressure, reset flush and
// random streaming against an arithmetic reference model.
module tb_fpaddsub_normalize_pack;
    import fpaddsub_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_sign;
    logic [32:0] in_sum;
    logic [7:0]  in_cexp;
    logic        out_valid, out_ready, out_ovf, out_unf, out_zero;
    logic [31:0] out_result;

    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;
    logic [34:0] exp_q[$];

    always #5 clk = ~clk;

    fpaddsub_normalize_pack dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_cexp    (in_cexp),
        .in_sign    (in_sign),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ovf    (out_ovf),
        .out_unf    (out_unf),
        .out_zero   (out_zero)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Value = sum * 2^(cexp-158); round exactly to 24 significant bits, ties to even.
    // Returns {zero, unf, ovf, result}.
    function automatic logic [34:0] ref_model(input logic [32:0] sum, input logic [7:0] cexp,
                                              input logic sgn);
        longint s, kept, rem, half;
        int     p, e, sh;
        if (sum == 33'd0) return {3'b100, 32'h0};
        s = longint'(sum);
        p = 0;
        for (int i = 0; i < 33; i++) if (s[i]) p = i;
        e = int'(cexp) + p - 31;
        if (e <= 0) return {3'b010, sgn, 31'h0};
        if (p >= 23) begin
            sh   = p - 23;
            kept = s >> sh;
            rem  = s - (kept << sh);
            if (sh > 0) begin
                half = longint'(1) << (sh - 1);
                if (rem > half || (rem == half && kept[0])) kept = kept + 1;
            end
        end else begin
            kept = s << (23 - p);
        end
        if (kept == (longint'(1) << 24)) begin
            kept = kept >> 1;
            e    = e + 1;
        end
        if (e >= 255) return {3'b001, sgn, 8'hFF, 23'h0};
        return {3'b000, sgn, e[7:0], kept[22:0]};
    endfunction

    task automatic rand_beat();
        logic [63:0] r;
        int          sel;
        r       = {$urandom, $urandom};
        in_sum  = r[32:0] >> $urandom_range(0, 33);
        if ($urandom_range(0, 3) == 0) in_sum[5:0] = 6'd0;
        sel     = $urandom_range(0, 7);
        in_cexp = (sel == 0) ? 8'($urandom_range(0, 6)) :
                  (sel == 1) ? 8'($urandom_range(249, 255)) : 8'($urandom_range(0, 255));
        in_sign = 1'($urandom_range(0, 1));
    endtask

    // Scoreboard and output-hold monitor, sampled mid-cycle
    logic [34:0] held;
    logic        stalled = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled)
                check_eq("hold_stable", {out_zero, out_unf, out_ovf, out_result, out_valid},
                         {held, 1'b1});
            if (in_valid && in_ready)
                exp_q.push_back(ref_model(in_sum, in_cexp, in_sign));
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) check_eq("spurious_out", 1, 0);
                else check_eq("stream_result", {out_zero, out_unf, out_ovf, out_result},
                              exp_q.pop_front());
            end
            if (out_valid && !out_ready) check_eq("in_ready_stall", in_ready, 0);
            stalled = out_valid && !out_ready;
            held    = {out_zero, out_unf, out_ovf, out_result};
        end
    end

    task automatic directed(input string tag, input logic [32:0] sum, input logic [7:0] cexp,
                            input logic sgn, input logic [31:0] exp_res, input logic [2:0] exp_fl);
        int lat;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sum    = sum;
        in_cexp   = cexp;
        in_sign   = sgn;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_latency"}, lat, 3);
        check_eq({tag, "_result"}, out_result, exp_res);
        check_eq({tag, "_flags"}, {out_zero, out_unf, out_ovf}, exp_fl);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   n0, sent, cyc, anyv;
        logic acc;
        rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_cexp = '0; in_sign = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_result", out_result, 0);
        check_eq("rst_flags", {out_zero, out_unf, out_ovf}, 0);
        check_eq("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        directed("carry_2p0",  33'h1_0000_0000, 8'd127, 1'b0, 32'h4000_0000, 3'b000);
        directed("half",       33'h0_4000_0000, 8'd127, 1'b0, 32'h3F00_0000, 3'b000);
        directed("exact_zero", 33'h0_0000_0000, 8'd127, 1'b1, 32'h0000_0000, 3'b100);
        directed("tie_even",   33'h0_8000_0080, 8'd127, 1'b0, 32'h3F80_0000, 3'b000);
        directed("tie_odd",    33'h0_8000_0180, 8'd127, 1'b0, 32'h3F80_0002, 3'b000);
        directed("round_cy",   33'h0_FFFF_FF80, 8'd127, 1'b0, 32'h4000_0000, 3'b000);
        directed("overflow",   33'h1_0000_0000, 8'd254, 1'b1, 32'hFF80_0000, 3'b001);
        directed("underflow",  33'h0_0000_0100, 8'd10,  1'b0, 32'h0000_0000, 3'b010);

        // Backpressure: 6 beats with a 5-cycle downstream stall in the middle
        @(posedge clk); #1;
        n0 = n_out; sent = 0; cyc = 0;
        in_valid = 1'b1;
        rand_beat();
        while (sent < 6 && cyc < 100) begin
            out_ready = !(cyc >= 3 && cyc < 8);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                sent++;
                rand_beat();
                if (sent == 6) in_valid = 1'b0;
            end
        end
        out_ready = 1'b1;
        for (int k = 0; k < 20 && n_out < n0 + 6; k++) @(posedge clk);
        #1;
        check_eq("bp_count", n_out - n0, 6);
        check_eq("bp_queue_empty", exp_q.size(), 0);

        // Reset with three beats in flight
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            rand_beat();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_out_result", out_result, 0);
        exp_q.delete();
        rst = 1'b0;
        anyv = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (out_valid) anyv++;
        end
        check_eq("midrst_no_stale", anyv, 0);

        // Random streaming with random backpressure
        in_valid = 1'b0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                rand_beat();
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        check_eq("drain_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
